// File: rtl/ser_tx_sched_if.sv
// Requester and serializer handshake bundle for ser_tx_sched.
// The slave modport is the scheduler; the master modport is its environment.
interface ser_tx_sched_if;
    logic        fwd_en;
    logic        fwd_valid;
    logic [31:0] fwd_data;
    logic        fwd_ready;
    logic        stat_valid;
    logic [31:0] stat_data;
    logic        stat_ready;
    logic        ser_ready;
    logic        ser_load;
    logic [31:0] ser_data;

    modport master (
        output fwd_en, fwd_valid, fwd_data, stat_valid, stat_data, ser_ready,
        input  fwd_ready, stat_ready, ser_load, ser_data
    );

    modport slave (
        input  fwd_en, fwd_valid, fwd_data, stat_valid, stat_data, ser_ready,
        output fwd_ready, stat_ready, ser_load, ser_data
    );
endinterface

// File: rtl/ser_tx_sched.sv
// Arbitrates forward and status words onto the shared 32-bit serializer,
// supervises the load/busy handshake and counts completed words per source.
module ser_tx_sched #(
    parameter int TIMEOUT    = 64,
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    ser_tx_sched_if.slave    bus,
    output logic [CNT_W-1:0] fwd_cnt,
    output logic [CNT_W-1:0] stat_cnt,
    output logic             err_timeout,
    output logic             busy
);
    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_GRANT      = 3'd1;
    localparam logic [2:0] S_LOAD       = 3'd2;
    localparam logic [2:0] S_WAIT_START = 3'd3;
    localparam logic [2:0] S_WAIT_DONE  = 3'd4;

    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int STV_W = $clog2(STARVE_MAX + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [STV_W-1:0] STV_FULL = STV_W'(STARVE_MAX);

    logic [2:0]       state_r;
    logic [2:0]       state_nx_s;
    logic [31:0]      hold_r;
    logic             src_fwd_r;
    logic [STV_W-1:0] starve_r;
    logic [TMR_W-1:0] timer_r;
    logic [TMR_W-1:0] timer_nx_s;
    logic             ser_load_r;
    logic [CNT_W-1:0] fwd_cnt_r;
    logic [CNT_W-1:0] stat_cnt_r;
    logic             err_r;
    logic             busy_r;

    logic idle_s;
    logic starve_full_s;
    logic fwd_ready_s;
    logic stat_ready_s;
    logic fwd_hs_s;
    logic stat_hs_s;
    logic timer_exp_s;
    logic done_s;
    logic tmo_s;

    // Ready generation; gated by rst so nothing is offered while in reset.
    always_comb begin
        idle_s        = (state_r == S_IDLE) && !rst;
        starve_full_s = (starve_r == STV_FULL);
        fwd_ready_s   = idle_s && bus.fwd_en && (!bus.stat_valid || starve_full_s);
        stat_ready_s  = idle_s && !fwd_ready_s;
        fwd_hs_s      = bus.fwd_valid && fwd_ready_s;
        stat_hs_s     = bus.stat_valid && stat_ready_s;
        timer_exp_s   = (timer_r == TMR_LAST);
    end

    // Next-state and handshake supervision timer.
    always_comb begin
        state_nx_s = state_r;
        timer_nx_s = timer_r;
        done_s     = 1'b0;
        tmo_s      = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (fwd_hs_s || stat_hs_s) begin
                    state_nx_s = S_GRANT;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_GRANT: begin
                if (bus.ser_ready) begin
                    state_nx_s = S_LOAD;
                end else begin
                    state_nx_s = S_GRANT;
                end
            end
            S_LOAD: begin
                state_nx_s = S_WAIT_START;
                timer_nx_s = '0;
            end
            S_WAIT_START: begin
                if (!bus.ser_ready) begin
                    state_nx_s = S_WAIT_DONE;
                    timer_nx_s = '0;
                end else if (timer_exp_s) begin
                    state_nx_s = S_IDLE;
                    timer_nx_s = '0;
                    tmo_s      = 1'b1;
                end else begin
                    timer_nx_s = timer_r + TMR_W'(1);
                end
            end
            S_WAIT_DONE: begin
                if (bus.ser_ready) begin
                    state_nx_s = S_IDLE;
                    timer_nx_s = '0;
                    done_s     = 1'b1;
                end else if (timer_exp_s) begin
                    state_nx_s = S_IDLE;
                    timer_nx_s = '0;
                    tmo_s      = 1'b1;
                end else begin
                    timer_nx_s = timer_r + TMR_W'(1);
                end
            end
            default: begin
                state_nx_s = S_IDLE;
                timer_nx_s = '0;
            end
        endcase
    end

    // State, holding register, starve tracking, counters and flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= S_IDLE;
            timer_r    <= '0;
            hold_r     <= 32'd0;
            src_fwd_r  <= 1'b0;
            starve_r   <= '0;
            ser_load_r <= 1'b0;
            fwd_cnt_r  <= '0;
            stat_cnt_r <= '0;
            err_r      <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            timer_r    <= timer_nx_s;
            ser_load_r <= (state_nx_s == S_LOAD);
            busy_r     <= (state_nx_s != S_IDLE);

            if (fwd_hs_s) begin
                hold_r    <= bus.fwd_data;
                src_fwd_r <= 1'b1;
            end else if (stat_hs_s) begin
                hold_r    <= bus.stat_data;
                src_fwd_r <= 1'b0;
            end

            // A pending fwd word only ages while it is both valid and enabled.
            if (!bus.fwd_valid || fwd_hs_s) begin
                starve_r <= '0;
            end else if (stat_hs_s && bus.fwd_en && !starve_full_s) begin
                starve_r <= starve_r + STV_W'(1);
            end

            if (done_s && src_fwd_r && (fwd_cnt_r != {CNT_W{1'b1}})) begin
                fwd_cnt_r <= fwd_cnt_r + CNT_W'(1);
            end
            if (done_s && !src_fwd_r && (stat_cnt_r != {CNT_W{1'b1}})) begin
                stat_cnt_r <= stat_cnt_r + CNT_W'(1);
            end
            if (tmo_s) begin
                err_r <= 1'b1;
            end
        end
    end

    assign bus.fwd_ready  = fwd_ready_s;
    assign bus.stat_ready = stat_ready_s;
    assign bus.ser_load   = ser_load_r;
    assign bus.ser_data   = hold_r;
    assign fwd_cnt        = fwd_cnt_r;
    assign stat_cnt       = stat_cnt_r;
    assign err_timeout    = err_r;
    assign busy           = busy_r;
endmodule

// File: tb/tb_ser_tx_sched.sv
// Scoreboard bench for ser_tx_sched: accepted words are queued at handshake
// and compared against ser_data when the scheduler pulses ser_load.
module tb_ser_tx_sched;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [CNT_W-1:0] fwd_cnt;
    logic [CNT_W-1:0] stat_cnt;
    logic             err_timeout;
    logic             busy;

    ser_tx_sched_if bus();

    ser_tx_sched #(.TIMEOUT(64), .STARVE_MAX(4), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .fwd_cnt     (fwd_cnt),
        .stat_cnt    (stat_cnt),
        .err_timeout (err_timeout),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [32:0] exp_q[$];
    int          f_left, s_left, ser_cnt, busy_len;
    int          cyc = 0, loads, grants, hs_cyc, load_cyc;
    bit          stuck, hs_f, hs_s, saw_fready;
    logic [15:0] grant_log;

    // One clock: serializer model and scoreboard pop, then requester drive and push.
    task automatic tick();
        logic [32:0] exp;
        @(posedge clk);
        #1;
        cyc++;
        if (hs_f) bus.fwd_data = bus.fwd_data + 32'd1;
        if (hs_s) bus.stat_data = bus.stat_data + 32'd1;
        if (ser_cnt > 0) begin
            ser_cnt--;
            if (ser_cnt == 0) bus.ser_ready = 1'b1;
        end
        if (bus.ser_load === 1'b1) begin
            loads++;
            load_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL ser_data: load with nothing accepted, got %h", bus.ser_data);
            end else begin
                exp = exp_q.pop_front();
                if (bus.ser_data !== exp[31:0]) begin
                    failures++;
                    $display("FAIL ser_data: got %h expected %h", bus.ser_data, exp[31:0]);
                end
            end
            if (!stuck) begin
                bus.ser_ready = 1'b0;
                ser_cnt = busy_len;
            end
        end
        bus.fwd_valid  = (f_left > 0);
        bus.stat_valid = (s_left > 0);
        #1;
        hs_f = bus.fwd_valid && (bus.fwd_ready === 1'b1);
        hs_s = bus.stat_valid && (bus.stat_ready === 1'b1);
        if (bus.fwd_ready === 1'b1) saw_fready = 1'b1;
        checks++;
        if ((bus.fwd_ready === 1'b1) && (bus.stat_ready === 1'b1)) begin
            failures++;
            $display("FAIL one_ready: fwd_ready=%b stat_ready=%b expected not both 1",
                     bus.fwd_ready, bus.stat_ready);
        end
        if (hs_f) begin
            exp_q.push_back({1'b1, bus.fwd_data});
            f_left--;
            if (grants < 16) grant_log[grants] = 1'b1;
            grants++;
            hs_cyc = cyc;
        end
        if (hs_s) begin
            exp_q.push_back({1'b0, bus.stat_data});
            s_left--;
            if (grants < 16) grant_log[grants] = 1'b0;
            grants++;
            hs_cyc = cyc;
        end
    endtask

    task automatic run_idle(input int max_cyc, input string name);
        int n = 0;
        while ((f_left > 0 || s_left > 0 || busy !== 1'b0 || ser_cnt > 0 || exp_q.size() > 0)
               && n < max_cyc) begin
            tick();
            n++;
        end
        checks++;
        if (n >= max_cyc) begin
            failures++;
            $display("FAIL %s_drain: still busy after %0d cycles, required idle", name, n);
        end
    endtask

    task automatic wait_load(input int max_cyc, input int target, input string name);
        int n = 0;
        while (loads < target && n < max_cyc) begin
            tick();
            n++;
        end
        checks++;
        if (loads < target) begin
            failures++;
            $display("FAIL %s_load: loads=%0d required %0d", name, loads, target);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.fwd_en = 1'b0;  bus.fwd_valid = 1'b0;  bus.fwd_data = 32'd0;
        bus.stat_valid = 1'b0;  bus.stat_data = 32'd0;  bus.ser_ready = 1'b1;
        f_left = 0;  s_left = 0;  ser_cnt = 0;  busy_len = 4;  stuck = 1'b0;
        hs_f = 1'b0;  hs_s = 1'b0;  loads = 0;  grants = 0;  grant_log = 16'd0;
        saw_fready = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus.ser_load, bus.ser_data, fwd_cnt, stat_cnt, err_timeout, busy} !== 43'd0) begin
            failures++;
            $display("FAIL reset_outputs: load=%b data=%h fc=%0d sc=%0d err=%b busy=%b required all 0",
                     bus.ser_load, bus.ser_data, fwd_cnt, stat_cnt, err_timeout, busy);
        end
        checks++;
        if ({bus.fwd_ready, bus.stat_ready} !== 2'b00) begin
            failures++;
            $display("FAIL reset_ready: got %b%b required 00", bus.fwd_ready, bus.stat_ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_fwd();
        do_reset();
        rst = 1'b0;
        bus.fwd_en = 1'b1;  bus.fwd_data = 32'hA5A5_0001;  busy_len = 32;  f_left = 1;
        wait_load(20, 1, "single");
        checks++;
        if (load_cyc - hs_cyc != 2) begin
            failures++;
            $display("FAIL single_latency: got %0d cycles required 2", load_cyc - hs_cyc);
        end
        run_idle(100, "single");
        checks++;
        if (fwd_cnt !== 4'd1 || stat_cnt !== 4'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_done: fc=%0d sc=%0d busy=%b required 1 0 0", fwd_cnt, stat_cnt, busy);
        end
    endtask

    task automatic test_contention();
        do_reset();
        rst = 1'b0;
        bus.fwd_en = 1'b1;  bus.fwd_data = 32'hF000_0000;  bus.stat_data = 32'h5000_0000;
        busy_len = 3;  f_left = 2;  s_left = 8;
        run_idle(400, "contention");
        checks++;
        if (grant_log[9:0] !== 10'b10_0001_0000 || grants != 10) begin
            failures++;
            $display("FAIL contention_order: got %b (%0d grants) required 1000010000 (10)",
                     grant_log[9:0], grants);
        end
        checks++;
        if (stat_cnt !== 4'd8 || fwd_cnt !== 4'd2) begin
            failures++;
            $display("FAIL contention_cnt: sc=%0d fc=%0d required 8 2", stat_cnt, fwd_cnt);
        end
    endtask

    task automatic test_fwd_disabled();
        do_reset();
        rst = 1'b0;
        bus.fwd_en = 1'b0;  bus.fwd_data = 32'hDEAD_0000;  f_left = 1;
        repeat (40) tick();
        checks++;
        if (saw_fready || loads != 0 || fwd_cnt !== 4'd0 || stat_cnt !== 4'd0) begin
            failures++;
            $display("FAIL fwd_disabled: ready_seen=%b loads=%0d fc=%0d sc=%0d required 0 0 0 0",
                     saw_fready, loads, fwd_cnt, stat_cnt);
        end
        f_left = 0;
    endtask

    task automatic test_timeout();
        int n = 0;
        do_reset();
        rst = 1'b0;
        stuck = 1'b1;  bus.stat_data = 32'h5A00_0000;  s_left = 1;
        wait_load(20, 1, "timeout");
        while (cyc < load_cyc + 60) tick();
        checks++;
        if (err_timeout !== 1'b0) begin
            failures++;
            $display("FAIL timeout_early: err=%b at %0d cycles after load required 0",
                     err_timeout, cyc - load_cyc);
        end
        while (err_timeout !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (err_timeout !== 1'b1 || cyc - load_cyc < 64 || cyc - load_cyc > 66) begin
            failures++;
            $display("FAIL timeout_flag: err=%b at %0d cycles after load required 1 at 64..66",
                     err_timeout, cyc - load_cyc);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || stat_cnt !== 4'd0 || fwd_cnt !== 4'd0) begin
            failures++;
            $display("FAIL timeout_drop: busy=%b sc=%0d fc=%0d required 0 0 0", busy, stat_cnt, fwd_cnt);
        end
        stuck = 1'b0;  busy_len = 5;  bus.stat_data = 32'h5A00_0100;  s_left = 1;
        run_idle(100, "timeout_next");
        checks++;
        if (stat_cnt !== 4'd1 || err_timeout !== 1'b1) begin
            failures++;
            $display("FAIL timeout_next: sc=%0d err=%b required 1 1", stat_cnt, err_timeout);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        rst = 1'b0;
        busy_len = 2;  bus.stat_data = 32'h0000_1000;  s_left = 17;
        run_idle(600, "saturation");
        checks++;
        if (stat_cnt !== 4'd15 || loads != 17) begin
            failures++;
            $display("FAIL saturation: sc=%0d loads=%0d required 15 17", stat_cnt, loads);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        rst = 1'b0;
        busy_len = 32;  bus.stat_data = 32'h7777_0000;  s_left = 1;
        wait_load(20, 1, "reset_mid");
        repeat (5) tick();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.ser_load, bus.ser_data, busy, stat_cnt, bus.fwd_ready, bus.stat_ready} !== 40'd0) begin
            failures++;
            $display("FAIL reset_mid: load=%b data=%h busy=%b sc=%0d rdy=%b%b required all 0",
                     bus.ser_load, bus.ser_data, busy, stat_cnt, bus.fwd_ready, bus.stat_ready);
        end
        exp_q.delete();
        ser_cnt = 0;  bus.ser_ready = 1'b1;  s_left = 0;  hs_f = 1'b0;  hs_s = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.fwd_en = 1'b1;  bus.fwd_data = 32'h1234_5678;  f_left = 1;
        run_idle(100, "reset_mid");
        checks++;
        if (fwd_cnt !== 4'd1 || stat_cnt !== 4'd0) begin
            failures++;
            $display("FAIL reset_mid_after: fc=%0d sc=%0d required 1 0", fwd_cnt, stat_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_fwd();
        test_contention();
        test_fwd_disabled();
        test_timeout();
        test_saturation();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
